// File: rtl/codec_i2c_config.sv
// Write-only I2C configuration master: walks a command table and sends each
// 16-bit word to the codec. Optional NACK detection and retry: CODEC_I2C_ACK_CHECK_EN.
//
// state   | meaning
// IDLE    | bus idle, waiting for start
// START   | START condition (2 quarters)
// BIT     | 27 bit slots, 4 quarters each
// STOP    | STOP condition (3 quarters)
// GAP     | bus idle between commands (4 quarters)
// DONE    | all commands acknowledged
// ERR     | retries exhausted on cmd_idx
module codec_i2c_config #(
   parameter int         CLK_DIV   = 125,
   parameter int         NUM_CMDS  = 4,
   parameter logic [6:0] DEV_ADDR  = 7'h1A,
   parameter int         MAX_RETRY = 3,
   parameter int         IDX_W     = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [IDX_W-1:0] cmd_idx,
   input  logic [15:0]      cmd_data,
   output logic             scl_o,
   output logic             sda_oe,
   input  logic             sda_i,
   output logic             busy,
   output logic             done,
   output logic             error
);
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_BIT, S_STOP, S_GAP, S_DONE, S_ERR
   } state_t;

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_t        state;
   logic [CW-1:0] qcnt;
   logic [1:0]    qtr;
   logic [4:0]    slot;
   logic [26:0]   shreg;
   logic          tick;
   logic          nack;

   assign tick = (qcnt == CW'(CLK_DIV - 1));

`ifdef CODEC_I2C_ACK_CHECK_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0] retry;
   logic          error_r;
   logic          ack_slot;
   assign ack_slot = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
   assign error    = error_r;
`else
   localparam int unused_max_retry = MAX_RETRY;
   logic unused_sda;
   assign unused_sda = sda_i;
   assign nack       = 1'b0;
   assign error      = 1'b0;
`endif

   // ACK slots carry a 1 so SDA is released for the slave
   function automatic logic [26:0] frame(input logic [15:0] d);
      return {DEV_ADDR, 1'b0, 1'b1, d[15:8], 1'b1, d[7:0], 1'b1};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         qcnt    <= '0;
         qtr     <= '0;
         slot    <= '0;
         shreg   <= '0;
         scl_o   <= 1'b1;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         cmd_idx <= '0;
`ifdef CODEC_I2C_ACK_CHECK_EN
         nack    <= 1'b0;
         retry   <= '0;
         error_r <= 1'b0;
`endif
      end else begin
         if (state == S_IDLE || state == S_DONE || state == S_ERR)
            qcnt <= '0;
         else
            qcnt <= tick ? '0 : qcnt + 1'b1;

         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state   <= S_START;
                  qtr     <= '0;
                  scl_o   <= 1'b1;
                  sda_oe  <= 1'b1;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  cmd_idx <= '0;
                  shreg   <= frame(cmd_data);
`ifdef CODEC_I2C_ACK_CHECK_EN
                  nack    <= 1'b0;
                  retry   <= '0;
                  error_r <= 1'b0;
`endif
               end
            end
            S_START: if (tick) begin
               if (qtr == 2'd0) begin
                  qtr   <= 2'd1;
                  scl_o <= 1'b0;
               end else begin
                  state  <= S_BIT;
                  qtr    <= '0;
                  slot   <= '0;
                  sda_oe <= ~shreg[26];
                  shreg  <= {shreg[25:0], 1'b0};
               end
            end
            S_BIT: if (tick) begin
               qtr <= qtr + 2'd1;
               case (qtr)
                  2'd0: scl_o <= 1'b1;
                  2'd1: begin
`ifdef CODEC_I2C_ACK_CHECK_EN
                     if (ack_slot && sda_i) nack <= 1'b1;
`endif
                  end
                  2'd2: scl_o <= 1'b0;
                  default: begin
                     if (slot == 5'd26 || nack) begin
                        state  <= S_STOP;
                        sda_oe <= 1'b1;
                     end else begin
                        slot   <= slot + 5'd1;
                        sda_oe <= ~shreg[26];
                        shreg  <= {shreg[25:0], 1'b0};
                     end
                  end
               endcase
            end
            S_STOP: if (tick) begin
               if (qtr == 2'd0) begin
                  qtr   <= 2'd1;
                  scl_o <= 1'b1;
               end else if (qtr == 2'd1) begin
                  qtr    <= 2'd2;
                  sda_oe <= 1'b0;
               end else begin
                  qtr <= '0;
`ifdef CODEC_I2C_ACK_CHECK_EN
                  if (nack) begin
                     if (retry < RW'(MAX_RETRY)) begin
                        retry <= retry + 1'b1;
                        state <= S_GAP;
                     end else begin
                        state   <= S_ERR;
                        error_r <= 1'b1;
                        busy    <= 1'b0;
                     end
                  end else
`endif
                  if (cmd_idx == IDX_W'(NUM_CMDS - 1)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     cmd_idx <= cmd_idx + 1'b1;
                     state   <= S_GAP;
`ifdef CODEC_I2C_ACK_CHECK_EN
                     retry   <= '0;
`endif
                  end
               end
            end
            S_GAP: if (tick) begin
               qtr <= qtr + 2'd1;
               if (qtr == 2'd3) begin
                  state  <= S_START;
                  sda_oe <= 1'b1;
                  shreg  <= frame(cmd_data);
`ifdef CODEC_I2C_ACK_CHECK_EN
                  nack   <= 1'b0;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_codec_i2c_config.sv
// Bench for codec_i2c_config: bus-level slave monitor with configurable NACK
// policy, table of run scenarios plus hand-written reset sequences.
module tb_codec_i2c_config;
   localparam int         CLK_DIV   = 2;
   localparam int         NUM_CMDS  = 3;
   localparam int         MAX_RETRY = 2;
   localparam logic [6:0] DEV_ADDR  = 7'h1A;
`ifdef CODEC_I2C_ACK_CHECK_EN
   localparam bit ACK_EN = 1'b1;
`else
   localparam bit ACK_EN = 1'b0;
`endif

   typedef struct {
      int policy;
      bit repulse;
      int exp_busy;
      int exp_frames;
      bit exp_done;
      bit exp_err;
      int exp_idx;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  cmd_idx;
   logic [15:0] cmd_data;
   logic        scl_o, sda_oe, sda_i, busy, done, error;
   logic        slave_pull = 1'b0;
   logic [15:0] tbl [4];

   int n_cmp = 0;
   int n_bad = 0;

   // bus monitor state
   int          policy = 0;
   int          frame_no = 0;
   int          cur_fno = 0;
   int          bitcnt = 0;
   bit          in_frame = 1'b0;
   logic [27:0] shift = '0;
   logic        p_scl = 1'b1, p_sda = 1'b1;
   logic [26:0] fr_bits[$];
   int          fr_len[$];
   logic [26:0] exp_bits[$];
   int          exp_len[$];

   always #5 clk = ~clk;

   assign sda_i    = ~sda_oe & ~slave_pull;
   assign cmd_data = busy ? tbl[cmd_idx] : tbl[0];

   codec_i2c_config #(
      .CLK_DIV(CLK_DIV), .NUM_CMDS(NUM_CMDS), .DEV_ADDR(DEV_ADDR),
      .MAX_RETRY(MAX_RETRY), .IDX_W(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cmd_idx(cmd_idx),
      .cmd_data(cmd_data), .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i),
      .busy(busy), .done(done), .error(error)
   );

   function automatic bit nacks(input int pol, input int fno, input int pos);
      case (pol)
         1: return (pos == 8) && (fno == 1);
         2: return pos == 17;
         3: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Slave/monitor: decodes START/STOP and bits from the bus, drives ACK.
   initial begin
      logic scl_n, sda_n;
      forever begin
         @(negedge clk);
         scl_n = scl_o;
         sda_n = sda_i;
         if (scl_n === 1'b1 && p_scl === 1'b1) begin
            if (p_sda === 1'b1 && sda_n === 1'b0) begin
               in_frame   = 1'b1;
               bitcnt     = 0;
               shift      = '0;
               cur_fno    = frame_no;
               frame_no   = frame_no + 1;
               slave_pull = 1'b0;
            end else if (p_sda === 1'b0 && sda_n === 1'b1 && in_frame) begin
               // STOP's SCL rise was counted as one extra bit
               fr_bits.push_back(shift[27:1]);
               fr_len.push_back(bitcnt - 1);
               in_frame = 1'b0;
               bitcnt   = 0;
            end
         end else if (scl_n === 1'b1 && p_scl === 1'b0 && in_frame) begin
            shift  = {shift[26:0], sda_n};
            bitcnt = bitcnt + 1;
         end else if (scl_n === 1'b0 && p_scl === 1'b1 && in_frame) begin
            if (bitcnt == 8 || bitcnt == 17 || bitcnt == 26)
               slave_pull = !nacks(policy, cur_fno, bitcnt);
            else
               slave_pull = 1'b0;
         end
         p_scl = scl_n;
         p_sda = sda_i;
      end
   end

   task automatic build_expect(input int pol);
      int cmd, retry, fno, n;
      bit a0, a1, a2, nk;
      logic [26:0] full;
      exp_bits.delete();
      exp_len.delete();
      cmd = 0; retry = 0; fno = 0;
      while (fno < 16) begin
         a0 = nacks(pol, fno, 8);
         a1 = nacks(pol, fno, 17);
         a2 = nacks(pol, fno, 26);
         full = {DEV_ADDR, 1'b0, a0, tbl[cmd][15:8], a1, tbl[cmd][7:0], a2};
         n = 27;
         nk = ACK_EN && (a0 || a1 || a2);
         if (ACK_EN && a0) n = 9;
         else if (ACK_EN && a1) n = 18;
         exp_bits.push_back(full >> (27 - n));
         exp_len.push_back(n);
         fno++;
         if (nk) begin
            if (retry < MAX_RETRY) retry++;
            else break;
         end else begin
            retry = 0;
            if (cmd == NUM_CMDS - 1) break;
            cmd++;
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int cnt;
      policy   = v.policy;
      frame_no = 0;
      fr_bits.delete();
      fr_len.delete();
      build_expect(v.policy);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cnt = 0;
      while (busy && cnt < 5000) begin
         start = (v.repulse && cnt == 300);
         cnt++;
         @(negedge clk);
      end
      start = 1'b0;
      check($sformatf("v%0d busy_cycles", k), cnt, v.exp_busy);
      check($sformatf("v%0d done", k), done, v.exp_done);
      check($sformatf("v%0d error", k), error, v.exp_err);
      check($sformatf("v%0d cmd_idx", k), cmd_idx, v.exp_idx);
      check($sformatf("v%0d scl_idle", k), scl_o, 1);
      check($sformatf("v%0d sda_oe_idle", k), sda_oe, 0);
      check($sformatf("v%0d frame_count", k), fr_len.size(), v.exp_frames);
      for (int i = 0; i < exp_len.size(); i++) begin
         if (i < fr_len.size()) begin
            check($sformatf("v%0d f%0d len", k, i), fr_len[i], exp_len[i]);
            check($sformatf("v%0d f%0d bits", k, i), fr_bits[i], exp_bits[i]);
         end
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      int cnt;
      tbl[0] = 16'h1E00;
      tbl[1] = 16'h0C42;
      tbl[2] = 16'h12A5;
      tbl[3] = 16'hFFFF;
      vecs[0] = '{0, 1'b0, 694, 3, 1'b1, 1'b0, 2};
      vecs[1] = '{1, 1'b0, ACK_EN ? 784 : 694, ACK_EN ? 4 : 3, 1'b1, 1'b0, 2};
      vecs[2] = '{2, 1'b0, ACK_EN ? 478 : 694, 3, !ACK_EN, ACK_EN, ACK_EN ? 0 : 2};
      vecs[3] = '{0, 1'b1, 694, 3, 1'b1, 1'b0, 2};
      vecs[4] = '{3, 1'b0, ACK_EN ? 262 : 694, 3, !ACK_EN, ACK_EN, ACK_EN ? 0 : 2};

      rst = 1'b1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset scl_o", scl_o, 1);
      check("reset sda_oe", sda_oe, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset error", error, 0);
      check("reset cmd_idx", cmd_idx, 0);

      for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

      // reset in the middle of slot 12
      policy = 0;
      frame_no = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cnt = 0;
      while (bitcnt < 12 && cnt < 2000) begin
         cnt++;
         @(negedge clk);
      end
      check("reached slot 12", bitcnt >= 12, 1);
      check("busy mid-frame", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst scl_o", scl_o, 1);
      check("midrst sda_oe", sda_oe, 0);
      check("midrst busy", busy, 0);
      check("midrst cmd_idx", cmd_idx, 0);
      repeat (3) @(negedge clk);
      run_vec(vecs[0], 5);

      // start coincident with reset: reset wins
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      check("rst+start busy", busy, 0);
      check("rst+start done", done, 0);
      check("rst+start sda_oe", sda_oe, 0);
      repeat (3) @(negedge clk);
      check("rst+start stays idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
